dmem_indirect: RTL and testbench



---
 rtl/dmem_indirect.sv | 174 +++++++++++++++++
 tb/tb_dmem_indirect.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_indirect.sv
// dmem_indirect: adapter between the pipeline data-memory port and the D-cache.
//
// Direct accesses (LDR/STR/LDB/STB/TRAP) pass straight through with no added
// latency. Indirect accesses (LDI/STI, flagged by `indirect`) are split into a
// pointer read, one idle cycle, and then the data read or write at the fetched
// pointer. The pipeline sees exactly one P_mem_resp per request.
//
// Optional feature: define DMEM_PTR_BYPASS_EN to add a one-entry pointer cache.
// A hit lets an indirect access skip the pointer read and the idle cycle.
//
// Ports:
//   clk, reset                       clock, async active-high reset
//   indirect                         current request is LDI/STI
//   P_mem_address/read/write         pipeline request (held until P_mem_resp)
//   P_mem_byte_enable/wdata          byte mask (direct only) and store data
//   P_mem_resp/rdata                 completion pulse and load data to pipeline
//   d_mem_address/read/write         D-cache request (held until d_mem_resp)
//   d_mem_byte_enable/wdata          D-cache byte mask and write data
//   d_mem_resp/rdata                 D-cache completion pulse and read data
module dmem_indirect (
   input  logic        clk,
   input  logic        reset,
   input  logic        indirect,
   input  logic [15:0] P_mem_address,
   input  logic        P_mem_read,
   input  logic        P_mem_write,
   input  logic [1:0]  P_mem_byte_enable,
   input  logic [15:0] P_mem_wdata,
   output logic        P_mem_resp,
   output logic [15:0] P_mem_rdata,
   output logic [15:0] d_mem_address,
   output logic        d_mem_read,
   output logic        d_mem_write,
   output logic [1:0]  d_mem_byte_enable,
   output logic [15:0] d_mem_wdata,
   input  logic        d_mem_resp,
   input  logic [15:0] d_mem_rdata
);

   typedef enum logic [2:0] {StIdle, StPtr, StGap, StDataRd, StDataWr} state_e;

   state_e      state_q, state_d;
   logic [15:0] ptr_q, ptr_d;
   logic        req;
   logic        byp_hit;
   logic [15:0] byp_val;

   assign req = P_mem_read | P_mem_write;

`ifdef DMEM_PTR_BYPASS_EN
   logic        byp_valid_q, byp_valid_d;
   logic [14:0] byp_tag_q, byp_tag_d;
   logic [15:0] byp_val_q, byp_val_d;

   assign byp_hit = byp_valid_q && (byp_tag_q == P_mem_address[15:1]);
   assign byp_val = byp_val_q;

   always_comb begin
      byp_valid_d = byp_valid_q;
      byp_tag_d   = byp_tag_q;
      byp_val_d   = byp_val_q;
      // Fill only while the request is still held, so the tag is meaningful.
      if (state_q == StPtr && d_mem_resp && req) begin
         byp_valid_d = 1'b1;
         byp_tag_d   = P_mem_address[15:1];
         byp_val_d   = d_mem_rdata;
      end
      // Any completed write to the cached pointer word makes the entry stale.
      if (d_mem_write && d_mem_resp && (d_mem_address[15:1] == byp_tag_q)) begin
         byp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byp_valid_q <= 1'b0;
         byp_tag_q   <= 15'h0000;
         byp_val_q   <= 16'h0000;
      end else begin
         byp_valid_q <= byp_valid_d;
         byp_tag_q   <= byp_tag_d;
         byp_val_q   <= byp_val_d;
      end
   end
`else
   assign byp_hit = 1'b0;
   assign byp_val = 16'h0000;
`endif

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (indirect && req) begin
               if (byp_hit) begin
                  ptr_d   = byp_val;
                  state_d = P_mem_read ? StDataRd : StDataWr;
               end else begin
                  state_d = StPtr;
               end
            end
         end
         StPtr: begin
            if (d_mem_resp) begin
               ptr_d   = d_mem_rdata;
               // A dropped request abandons the transaction after the read lands.
               state_d = req ? StGap : StIdle;
            end
         end
         StGap: begin
            if (!req) begin
               state_d = StIdle;
            end else begin
               state_d = P_mem_read ? StDataRd : StDataWr;
            end
         end
         StDataRd, StDataWr: begin
            if (d_mem_resp) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode; IDLE with a direct request is a pure combinational bypass.
   always_comb begin
      d_mem_address     = P_mem_address;
      d_mem_read        = 1'b0;
      d_mem_write       = 1'b0;
      d_mem_byte_enable = 2'b11;
      d_mem_wdata       = P_mem_wdata;
      P_mem_resp        = 1'b0;
      P_mem_rdata       = d_mem_rdata;
      unique case (state_q)
         StIdle: begin
            if (!indirect) begin
               d_mem_read        = P_mem_read;
               d_mem_write       = P_mem_write;
               d_mem_byte_enable = P_mem_byte_enable;
               P_mem_resp        = d_mem_resp;
            end
         end
         StPtr: begin
            d_mem_read    = 1'b1;
            d_mem_address = P_mem_address & 16'hFFFE;
         end
         StDataRd: begin
            d_mem_read    = 1'b1;
            d_mem_address = ptr_q & 16'hFFFE;
            P_mem_resp    = d_mem_resp & req;
         end
         StDataWr: begin
            d_mem_write   = 1'b1;
            d_mem_address = ptr_q & 16'hFFFE;
            P_mem_resp    = d_mem_resp & req;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         ptr_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_dmem_indirect.sv
`timescale 1ns/1ps
module tb_dmem_indirect;
`ifdef DMEM_PTR_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        indirect = 1'b0;
   logic [15:0] P_mem_address = 16'h0000;
   logic        P_mem_read = 1'b0;
   logic        P_mem_write = 1'b0;
   logic [1:0]  P_mem_byte_enable = 2'b00;
   logic [15:0] P_mem_wdata = 16'h0000;
   logic        P_mem_resp;
   logic [15:0] P_mem_rdata;
   logic [15:0] d_mem_address;
   logic        d_mem_read;
   logic        d_mem_write;
   logic [1:0]  d_mem_byte_enable;
   logic [15:0] d_mem_wdata;
   logic        d_mem_resp = 1'b0;
   logic [15:0] d_mem_rdata = 16'h0000;

   dmem_indirect dut (
      .clk               (clk),
      .reset             (reset),
      .indirect          (indirect),
      .P_mem_address     (P_mem_address),
      .P_mem_read        (P_mem_read),
      .P_mem_write       (P_mem_write),
      .P_mem_byte_enable (P_mem_byte_enable),
      .P_mem_wdata       (P_mem_wdata),
      .P_mem_resp        (P_mem_resp),
      .P_mem_rdata       (P_mem_rdata),
      .d_mem_address     (d_mem_address),
      .d_mem_read        (d_mem_read),
      .d_mem_write       (d_mem_write),
      .d_mem_byte_enable (d_mem_byte_enable),
      .d_mem_wdata       (d_mem_wdata),
      .d_mem_resp        (d_mem_resp),
      .d_mem_rdata       (d_mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] addr;
      logic        wr;
      logic [15:0] wdata;
      logic [1:0]  be;
      int          lat;
   } txn_t;

   logic [15:0] mem     [0:32767];  // backing store seen through the cache model
   logic [15:0] ref_mem [0:32767];  // reference model's view of memory
   txn_t        obs_q[$];
   txn_t        exp_q[$];
   txn_t        cur;
   bit          busy = 1'b0;
   int          cnt = 0;
   int          lat_force = -1;
   int          n_pass = 0;
   int          n_total = 0;
   // Reference pointer-cache entry
   bit          pv = 1'b0;
   logic [14:0] ptag = 15'h0;
   logic [15:0] pval = 16'h0;

   // D-cache model: evaluated once per cycle at the falling edge.
   task automatic cache_eval();
      logic [15:0] old;
      if (d_mem_read === 1'b1 || d_mem_write === 1'b1) begin
         if (!busy) begin
            busy      = 1'b1;
            cur.addr  = d_mem_address;
            cur.wr    = d_mem_write;
            cur.wdata = d_mem_wdata;
            cur.be    = d_mem_byte_enable;
            cur.lat   = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 3));
            cnt       = cur.lat;
         end else begin
            n_total++;
            if (d_mem_address !== cur.addr)
               $display("FAIL addr_stable: got %h want %h", d_mem_address, cur.addr);
            else
               n_pass++;
         end
         if (cnt == 0) begin
            if (cur.wr === 1'b1) begin
               old = mem[cur.addr[15:1]];
               mem[cur.addr[15:1]] = {cur.be[1] ? cur.wdata[15:8] : old[15:8],
                                      cur.be[0] ? cur.wdata[7:0]  : old[7:0]};
            end else begin
               d_mem_rdata = mem[cur.addr[15:1]];
            end
            d_mem_resp = 1'b1;
            obs_q.push_back(cur);
            busy = 1'b0;
         end else begin
            cnt--;
         end
      end else begin
         busy = 1'b0;
      end
   endtask

   // Cycle phases: drive point (posedge+1) -> step -> sample point -> advance.
   task automatic step();
      @(negedge clk);
      cache_eval();
      #2;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      d_mem_resp  = 1'b0;
      d_mem_rdata = 16'($urandom);
   endtask

   task automatic idle();
      indirect    = 1'b0;
      P_mem_read  = 1'b0;
      P_mem_write = 1'b0;
      step();
      advance();
   endtask

   task automatic set_word(input logic [15:0] a, input logic [15:0] v);
      mem[a[15:1]]     = v;
      ref_mem[a[15:1]] = v;
   endtask

   // Transaction-level reference: expected downstream accesses and load data.
   task automatic model_req(input bit ind, input bit rd, input bit wr, input logic [15:0] a,
                            input logic [15:0] wd, input logic [1:0] be,
                            output logic [15:0] rdata);
      txn_t        t;
      logic [15:0] p;
      logic [15:0] old;
      exp_q.delete();
      rdata   = 16'h0;
      t.lat   = 0;
      t.wdata = wd;
      if (!ind) begin
         t.addr = a;
         t.wr   = wr;
         t.be   = be;
         exp_q.push_back(t);
         if (rd) begin
            rdata = ref_mem[a[15:1]];
         end else begin
            old = ref_mem[a[15:1]];
            ref_mem[a[15:1]] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
            if (pv && ptag == a[15:1]) pv = 1'b0;
         end
      end else begin
         t.be = 2'b11;
         if (Bypass && pv && ptag == a[15:1]) begin
            p = pval;
         end else begin
            t.addr = {a[15:1], 1'b0};
            t.wr   = 1'b0;
            exp_q.push_back(t);
            p    = ref_mem[a[15:1]];
            pv   = 1'b1;
            ptag = a[15:1];
            pval = p;
         end
         t.addr = {p[15:1], 1'b0};
         t.wr   = !rd;
         exp_q.push_back(t);
         if (rd) begin
            rdata = ref_mem[p[15:1]];
         end else begin
            ref_mem[p[15:1]] = wd;
            if (pv && ptag == p[15:1]) pv = 1'b0;
         end
      end
   endtask

   // Present one request and wait (bounded) for P_mem_resp; request is left asserted.
   task automatic do_req(input bit ind, input bit rd, input bit wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic [1:0] be,
                         output logic [15:0] rdata, output int cyc, output bit ok);
      obs_q.delete();
      indirect          = ind;
      P_mem_read        = rd;
      P_mem_write       = wr;
      P_mem_address     = a;
      P_mem_wdata       = wd;
      P_mem_byte_enable = be;
      ok    = 1'b0;
      cyc   = 0;
      rdata = 16'hxxxx;
      while (!ok && cyc < 60) begin
         step();
         if (P_mem_resp === 1'b1) begin
            ok    = 1'b1;
            rdata = P_mem_rdata;
         end else begin
            cyc++;
         end
         advance();
      end
   endtask

   task automatic test_reset();
      P_mem_address = 16'h1234;
      step();
      n_total++;
      if (P_mem_resp !== 1'b0) $display("FAIL reset_resp: got %b want 0", P_mem_resp);
      else n_pass++;
      n_total++;
      if (d_mem_read !== 1'b0 || d_mem_write !== 1'b0)
         $display("FAIL reset_dreq: got rd=%b wr=%b want 0 0", d_mem_read, d_mem_write);
      else n_pass++;
      n_total++;
      if (d_mem_address !== 16'h1234)
         $display("FAIL reset_passthru: got %h want 1234", d_mem_address);
      else n_pass++;
      advance();
      reset = 1'b0;
      idle();
   endtask

   task automatic test_direct_read();
      logic [15:0] rd, mr;
      int          cyc;
      bit          ok;
      set_word(16'h0040, 16'hBEEF);
      lat_force = 3;
      model_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, mr);
      do_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, rd, cyc, ok);
      idle();
      n_total++;
      if (!ok || rd !== 16'hBEEF) $display("FAIL direct_rdata: got %h want beef", rd);
      else n_pass++;
      n_total++;
      if (cyc != 3) $display("FAIL direct_latency: got %0d want 3", cyc);
      else n_pass++;
      n_total++;
      if (obs_q.size() != 1 || obs_q[0].addr !== 16'h0040 || obs_q[0].wr !== 1'b0)
         $display("FAIL direct_txn: got n=%0d want 1 read of 0040", obs_q.size());
      else n_pass++;
   endtask

   task automatic test_sti();
      logic [15:0] rd, mr;
      int          cyc;
      bit          ok;
      set_word(16'h0100, 16'h3001);
      lat_force = 1;
      model_req(1'b1, 1'b0, 1'b1, 16'h0101, 16'hA5A5, 2'b00, mr);
      do_req(1'b1, 1'b0, 1'b1, 16'h0101, 16'hA5A5, 2'b00, rd, cyc, ok);
      idle();
      n_total++;
      if (!ok || cyc != 5) $display("FAIL sti_latency: got ok=%b cyc=%0d want 1 5", ok, cyc);
      else n_pass++;
      n_total++;
      if (obs_q.size() != 2) $display("FAIL sti_count: got %0d want 2", obs_q.size());
      else n_pass++;
      n_total++;
      if (obs_q.size() < 1 || obs_q[0].addr !== 16'h0100 || obs_q[0].wr !== 1'b0 ||
          obs_q[0].be !== 2'b11)
         $display("FAIL sti_ptr: want read of 0100 be 11");
      else n_pass++;
      n_total++;
      if (obs_q.size() < 2 || obs_q[1].addr !== 16'h3000 || obs_q[1].wr !== 1'b1 ||
          obs_q[1].wdata !== 16'hA5A5 || obs_q[1].be !== 2'b11)
         $display("FAIL sti_data: want write a5a5 to 3000 be 11");
      else n_pass++;
   endtask

   task automatic test_reset_mid_ptr();
      logic [15:0] rd;
      int          cyc;
      bit          ok;
      lat_force         = 6;
      indirect          = 1'b1;
      P_mem_read        = 1'b1;
      P_mem_write       = 1'b0;
      P_mem_address     = 16'h0100;
      P_mem_byte_enable = 2'b11;
      step();
      advance();
      step();
      n_total++;
      if (d_mem_read !== 1'b1) $display("FAIL rst_mid_ptr_active: got %b want 1", d_mem_read);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (d_mem_read !== 1'b0 || P_mem_resp !== 1'b0)
         $display("FAIL rst_mid_ptr_drop: got rd=%b resp=%b want 0 0", d_mem_read, P_mem_resp);
      else n_pass++;
      indirect   = 1'b0;
      P_mem_read = 1'b0;
      advance();
      reset = 1'b0;
      pv    = 1'b0;
      idle();
      lat_force = 3;
      do_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 2'b11, rd, cyc, ok);
      idle();
      n_total++;
      if (!ok || rd !== 16'hBEEF || cyc != 3)
         $display("FAIL rst_followup: got ok=%b rdata=%h cyc=%0d want 1 beef 3", ok, rd, cyc);
      else n_pass++;
   endtask

   task automatic test_ldi();
      logic [15:0] rd, mr;
      int          cyc;
      bit          ok;
      set_word(16'h0100, 16'h2002);
      set_word(16'h2002, 16'h1234);
      lat_force = 2;
      model_req(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00, mr);
      do_req(1'b1, 1'b1, 1'b0, 16'h0100, 16'h0000, 2'b00, rd, cyc, ok);
      idle();
      n_total++;
      if (!ok || rd !== 16'h1234) $display("FAIL ldi_rdata: got %h want 1234", rd);
      else n_pass++;
      n_total++;
      if (cyc != 7) $display("FAIL ldi_latency: got %0d want 7", cyc);
      else n_pass++;
      n_total++;
      if (obs_q.size() != 2 || obs_q[0].addr !== 16'h0100 || obs_q[0].be !== 2'b11 ||
          obs_q[1].addr !== 16'h2002 || obs_q[1].wr !== 1'b0)
         $display("FAIL ldi_txns: got n=%0d want reads of 0100 then 2002", obs_q.size());
      else n_pass++;
   endtask

   task automatic test_bypass();
      bit          s_ind[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int          s_n[5];
      logic [15:0] rd, mr;
      int          cyc;
      bit          ok;
      s_n = '{1, 2, (Bypass ? 1 : 2), 1, 2};
      lat_force = -1;
      for (int i = 0; i < 5; i++) begin
         model_req(s_ind[i], s_ind[i], !s_ind[i], 16'h0100, 16'h2002, 2'b11, mr);
         do_req(s_ind[i], s_ind[i], !s_ind[i], 16'h0100, 16'h2002, 2'b11, rd, cyc, ok);
         idle();
         n_total++;
         if (!ok || obs_q.size() != s_n[i])
            $display("FAIL bypass_count[%0d]: got ok=%b n=%0d want n=%0d", i, ok,
                     obs_q.size(), s_n[i]);
         else n_pass++;
         if (s_ind[i]) begin
            n_total++;
            if (rd !== 16'h1234) $display("FAIL bypass_rdata[%0d]: got %h want 1234", i, rd);
            else n_pass++;
         end
      end
   endtask

   task automatic test_random_stream(input int n, input bit b2b);
      logic [15:0] rd, mr, a, wd;
      logic [1:0]  be;
      bit          ind, r, w, ok;
      int          kind, cyc, exp_cyc;
      lat_force = -1;
      for (int k = 0; k < n; k++) begin
         kind = $urandom_range(0, 3);
         ind  = (kind >= 2);
         r    = (kind == 0) || (kind == 2);
         w    = (kind == 1) || (kind == 3) || ((kind == 2) && ($urandom_range(0, 3) == 0));
         a    = (ind || $urandom_range(0, 1) == 1) ? 16'($urandom_range(16'h0100, 16'h013F))
                                                   : 16'($urandom);
         wd   = 16'($urandom);
         be   = 2'($urandom_range(0, 3));
         model_req(ind, r, w, a, wd, be, mr);
         do_req(ind, r, w, a, wd, be, rd, cyc, ok);
         if (!b2b && $urandom_range(0, 1) == 1) idle();
         n_total++;
         if (!ok) $display("FAIL rand_timeout[%0d]: no response within 60 cycles", k);
         else n_pass++;
         if (r) begin
            n_total++;
            if (rd !== mr) $display("FAIL rand_rdata[%0d]: got %h want %h", k, rd, mr);
            else n_pass++;
         end
         n_total++;
         if (obs_q.size() != exp_q.size())
            $display("FAIL rand_count[%0d]: got %0d want %0d", k, obs_q.size(), exp_q.size());
         else n_pass++;
         for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_total++;
            if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].wr !== exp_q[i].wr ||
                obs_q[i].be !== exp_q[i].be ||
                (exp_q[i].wr && obs_q[i].wdata !== exp_q[i].wdata))
               $display("FAIL rand_txn[%0d.%0d]: got a=%h w=%b be=%b d=%h want a=%h w=%b be=%b d=%h",
                        k, i, obs_q[i].addr, obs_q[i].wr, obs_q[i].be, obs_q[i].wdata,
                        exp_q[i].addr, exp_q[i].wr, exp_q[i].be, exp_q[i].wdata);
            else n_pass++;
         end
         if (ok && obs_q.size() == exp_q.size() && exp_q.size() > 0) begin
            if (!ind) exp_cyc = obs_q[0].lat;
            else if (exp_q.size() == 2) exp_cyc = obs_q[0].lat + obs_q[1].lat + 3;
            else exp_cyc = obs_q[0].lat + 1;
            n_total++;
            if (cyc != exp_cyc) $display("FAIL rand_latency[%0d]: got %0d want %0d", k, cyc, exp_cyc);
            else n_pass++;
         end
      end
      idle();
   endtask

   initial begin
      for (int i = 0; i < 32768; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      // Some pointer slots point back into the pointer region to exercise invalidation.
      for (int i = 16'h0080; i < 16'h00A0; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            mem[i]     = 16'($urandom_range(16'h0100, 16'h013F));
            ref_mem[i] = mem[i];
         end
      end
      test_reset();
      test_direct_read();
      test_sti();
      test_reset_mid_ptr();
      test_ldi();
      test_bypass();
      test_random_stream(30, 1'b1);
      test_random_stream(40, 1'b0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
